// File: rtl/approx_eval_pkg.sv
// Shared types and default widths for the approximate-adder error monitors.
package approx_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_t;

  localparam int W     = 8;
  localparam int CNT_W = 17;
  localparam int SUM_W = CNT_W + W + 1;

endpackage

// File: rtl/approx_err_calc.sv
// Exact sum of two W-bit operands and its absolute distance from an approximate result.
module approx_err_calc #(
  parameter int W = 8
) (
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W:0]   approx_sum,
  output logic [W:0]   exact,
  output logic [W:0]   err
);

  // Exact sum and unsigned absolute error
  always_comb begin
    exact = {1'b0, in1} + {1'b0, in2};
    if (exact >= approx_sum) begin
      err = exact - approx_sum;
    end else begin
      err = approx_sum - exact;
    end
  end

endmodule

// File: rtl/approx_add_err_monitor.sv
// Error-statistics stage for an approximate W-bit adder: two-stage pipeline
// (error calc, then accumulate) under a run/drain/done controller.
module approx_add_err_monitor #(
  parameter int W     = approx_eval_pkg::W,
  parameter int CNT_W = approx_eval_pkg::CNT_W,
  parameter int SUM_W = CNT_W + W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in1,
  input  logic [W-1:0]     in2,
  input  logic [W:0]       approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [SUM_W-1:0] err_sum,
  output logic [W:0]       err_max,
  output logic [W-1:0]     err_max_in1,
  output logic [W-1:0]     err_max_in2,
  output logic [CNT_W-1:0] err_cnt
);
  import approx_eval_pkg::*;

  mon_state_t       state_r, state_nx;
  logic [CNT_W-1:0] n_lat_r, acc_r;
  logic             s1_valid_r;
  logic [W:0]       s1_err_r;
  logic [W-1:0]     s1_in1_r, s1_in2_r;
  logic [W:0]       exact_s, err_s;
  logic             hs_s, last_s, start_acc_s;

  approx_err_calc #(.W(W)) u_calc (
    .in1        (in1),
    .in2        (in2),
    .approx_sum (approx_sum),
    .exact      (exact_s),
    .err        (err_s)
  );

  assign in_ready    = (state_r == RUN) && (acc_r != n_lat_r);
  assign hs_s        = in_valid && in_ready;
  assign last_s      = (acc_r + CNT_W'(1)) == n_lat_r;
  assign start_acc_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign busy        = (state_r == RUN) || (state_r == DRAIN);
  assign done        = (state_r == DONE);

  // Next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nx = (n_samples == '0) ? DONE : RUN;
        end else begin
          state_nx = state_r;
        end
      end
      RUN: begin
        if (hs_s && last_s) begin
          state_nx = DRAIN;
        end else begin
          state_nx = RUN;
        end
      end
      DRAIN: begin
        if (!s1_valid_r) begin
          state_nx = DONE;
        end else begin
          state_nx = DRAIN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Pipeline stages, beat counter and statistics accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat_r     <= '0;
      acc_r       <= '0;
      s1_valid_r  <= 1'b0;
      s1_err_r    <= '0;
      s1_in1_r    <= '0;
      s1_in2_r    <= '0;
      sample_cnt  <= '0;
      err_sum     <= '0;
      err_max     <= '0;
      err_max_in1 <= '0;
      err_max_in2 <= '0;
      err_cnt     <= '0;
    end else begin
      s1_valid_r <= hs_s;
      if (hs_s) begin
        s1_err_r <= err_s;
        s1_in1_r <= in1;
        s1_in2_r <= in2;
        acc_r    <= acc_r + CNT_W'(1);
      end
      if (start_acc_s) begin
        n_lat_r     <= n_samples;
        acc_r       <= '0;
        sample_cnt  <= '0;
        err_sum     <= '0;
        err_max     <= '0;
        err_max_in1 <= '0;
        err_max_in2 <= '0;
        err_cnt     <= '0;
      end else if (s1_valid_r) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        err_sum    <= err_sum + SUM_W'(s1_err_r);
        if (s1_err_r != '0) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        // Strict compare: a tie keeps the first sample's operands
        if (s1_err_r > err_max) begin
          err_max     <= s1_err_r;
          err_max_in1 <= s1_in1_r;
          err_max_in2 <= s1_in2_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Directed self-checking bench for approx_add_err_monitor.
module tb_approx_add_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [16:0] n_samples = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in1 = '0;
  logic [7:0]  in2 = '0;
  logic [8:0]  approx_sum = '0;
  logic        busy, done;
  logic [16:0] sample_cnt, err_cnt;
  logic [25:0] err_sum;
  logic [8:0]  err_max;
  logic [7:0]  err_max_in1, err_max_in2;

  int checks = 0;
  int errors = 0;

  approx_add_err_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .approx_sum(approx_sum), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_sum(err_sum), .err_max(err_max),
    .err_max_in1(err_max_in1), .err_max_in2(err_max_in2), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic do_start(input logic [16:0] n);
    @(negedge clk);
    start = 1'b1;
    n_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one beat, wait (bounded) for in_ready, return at the negedge after the handshake
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic [8:0] s);
    int k;
    in1 = a; in2 = b; approx_sum = s; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL beat_ready: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%0b required 1", name, done);
    end
  endtask

  task automatic check_stats(input string name, input logic [16:0] sc, input logic [25:0] es,
                             input logic [16:0] ec, input logic [8:0] em,
                             input logic [7:0] ea, input logic [7:0] eb);
    checks++;
    if (sample_cnt !== sc || err_sum !== es || err_cnt !== ec ||
        err_max !== em || err_max_in1 !== ea || err_max_in2 !== eb) begin
      errors++;
      $display("FAIL %s_stats: got cnt=%0d sum=%0d ecnt=%0d max=%0d in1=%0d in2=%0d required cnt=%0d sum=%0d ecnt=%0d max=%0d in1=%0d in2=%0d",
               name, sample_cnt, err_sum, err_cnt, err_max, err_max_in1, err_max_in2,
               sc, es, ec, em, ea, eb);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%0b busy=%0b done=%0b required 0 0 0", in_ready, busy, done);
    end
    check_stats("reset_init", 17'd0, 26'd0, 17'd0, 9'd0, 8'd0, 8'd0);
    rst_n = 1'b1;
    do_start(17'd10);
    send_beat(8'd1, 8'd1, 9'd5);
    send_beat(8'd2, 8'd2, 9'd9);
    send_beat(8'd3, 8'd3, 9'd6);
    checks++;
    if (sample_cnt !== 17'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_prerun: cnt=%0d busy=%0b required 2 1", sample_cnt, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_ctrl: ready=%0b busy=%0b done=%0b required 0 0 0", in_ready, busy, done);
    end
    check_stats("reset_async", 17'd0, 26'd0, 17'd0, 9'd0, 8'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_error;
    do_start(17'd4);
    send_beat(8'd1, 8'd2, 9'd3);
    send_beat(8'd255, 8'd255, 9'd510);
    send_beat(8'd0, 8'd0, 9'd0);
    send_beat(8'd128, 8'd128, 9'd256);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_early: done=%0b required 0", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_latency: done=%0b busy=%0b required 1 0", done, busy);
    end
    check_stats("zero", 17'd4, 26'd0, 17'd0, 9'd0, 8'd0, 8'd0);
  endtask

  task automatic test_mixed_tie;
    do_start(17'd3);
    send_beat(8'd3, 8'd5, 9'd10);
    send_beat(8'd7, 8'd1, 9'd4);
    send_beat(8'd2, 8'd2, 9'd0);
    wait_done("mixed");
    check_stats("mixed", 17'd3, 26'd10, 17'd3, 9'd4, 8'd7, 8'd1);
  endtask

  task automatic test_backpressure;
    int hs;
    logic prev_hs;
    hs = 0;
    prev_hs = 1'b0;
    do_start(17'd2);
    in1 = 8'd1; in2 = 8'd1; approx_sum = 9'd2; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (hs == 2 && prev_hs) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready_drop: in_ready=%0b required 0", in_ready);
        end
      end
      prev_hs = in_ready;
      if (in_ready) hs++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (hs != 2) begin
      errors++;
      $display("FAIL bp_accepted: got %0d required 2", hs);
    end
    wait_done("bp");
    check_stats("bp", 17'd2, 26'd0, 17'd0, 9'd0, 8'd0, 8'd0);
  endtask

  task automatic test_zero_restart;
    do_start(17'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL n0_done: done=%0b busy=%0b required 1 0", done, busy);
    end
    check_stats("n0", 17'd0, 26'd0, 17'd0, 9'd0, 8'd0, 8'd0);
    do_start(17'd1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_ctrl: done=%0b busy=%0b ready=%0b required 0 1 1", done, busy, in_ready);
    end
    do_start(17'd5);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start: busy=%0b ready=%0b done=%0b required 1 1 0", busy, in_ready, done);
    end
    send_beat(8'd10, 8'd20, 9'd31);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_limit: in_ready=%0b required 0", in_ready);
    end
    wait_done("restart");
    check_stats("restart", 17'd1, 26'd1, 17'd1, 9'd1, 8'd10, 8'd20);
  endtask

  task automatic test_back_to_back_sweep;
    int cycles;
    int k;
    logic [8:0] ex;
    cycles = 0;
    do_start(17'h10000);
    in_valid = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        in1 = 8'(a);
        in2 = 8'(b);
        ex = 9'(a + b);
        approx_sum = ex + 9'd1;
        k = 0;
        while (!in_ready && k < 10) begin
          @(negedge clk);
          k++;
          cycles++;
        end
        @(negedge clk);
        cycles++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (cycles != 65536) begin
      errors++;
      $display("FAIL sweep_rate: cycles=%0d required 65536", cycles);
    end
    wait_done("sweep");
    check_stats("sweep", 17'h10000, 26'd65536, 17'h10000, 9'd1, 8'd0, 8'd0);
  endtask

  initial begin
    test_reset();
    test_zero_error();
    test_mixed_tie();
    test_backpressure();
    test_zero_restart();
    test_back_to_back_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
